// File: rtl/riscv_pre_decoder_align.sv
// Pre-decode and realignment stage: splits word-aligned fetch words into 16/32-bit
// instructions, tags each with PC and control-flow flags, and queues them in a FWFT FIFO.
module riscv_pre_decoder_align #(
  parameter int unsigned RVC_EN = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o,
  output logic        is_branch_o,
  output logic        is_jal_o,
  output logic        is_jalr_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        br;
    logic        jal;
    logic        jalr;
  } entry_t;

  typedef enum logic [1:0] {
    ALIGNED  = 2'd0,
    HALF     = 2'd1,
    SKIP_LOW = 2'd2
  } state_t;

  function automatic logic rvc(input logic [1:0] q);
    return (RVC_EN != 0) && (q != 2'b11);
  endfunction

  function automatic entry_t mk(input logic [31:0] ins, input logic [31:0] addr, input logic c);
    entry_t e;
    e.instr = ins;
    e.pc    = addr;
    e.comp  = c;
    e.br    = 1'b0;
    e.jal   = 1'b0;
    e.jalr  = 1'b0;
    if (c) begin
      if (ins[1:0] == 2'b01) begin
        e.jal = (ins[15:13] == 3'b001) || (ins[15:13] == 3'b101);
        e.br  = (ins[15:13] == 3'b110) || (ins[15:13] == 3'b111);
      end else if (ins[1:0] == 2'b10) begin
        e.jalr = (ins[15:13] == 3'b100) && (ins[11:7] != 5'd0) && (ins[6:2] == 5'd0);
      end
    end else begin
      e.br   = (ins[6:0] == 7'b1100011);
      e.jal  = (ins[6:0] == 7'b1101111);
      e.jalr = (ins[6:0] == 7'b1100111) && (ins[14:12] == 3'b000);
    end
    return e;
  endfunction

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_n;
  logic [15:0]   hold;
  logic [15:0]   hold_n;
  logic [31:0]   hpc;
  logic [31:0]   hpc_n;

  logic [15:0]   lo;
  logic [15:0]   hi;
  logic [31:0]   a2;
  logic          fire;
  logic          pop;
  logic          upper;
  logic [1:0]    npush;
  logic [1:0]    push_n;
  entry_t        e0;
  entry_t        e1;
  entry_t        up_e;
  entry_t        head;
  logic          unused_flush_pc;

  // Only bit 1 of the restart PC matters: it selects whether the first fetched low half is skipped.
  assign unused_flush_pc = ^{flush_pc_i[31:2], flush_pc_i[0]};

  assign lo            = fetch_rdata_i[15:0];
  assign hi            = fetch_rdata_i[31:16];
  assign a2            = fetch_addr_i + 32'd2;
  assign fetch_ready_o = ~rst && ((CW'(DEPTH) - count) >= CW'(2));
  assign instr_valid_o = (count != '0);
  assign fire          = fetch_valid_i && fetch_ready_o && ~flush_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign push_n        = fire ? npush : 2'd0;

  always_comb begin
    npush   = 2'd0;
    e0      = '0;
    e1      = '0;
    up_e    = '0;
    upper   = 1'b0;
    state_n = state;
    hold_n  = hold;
    hpc_n   = hpc;
    unique case (state)
      ALIGNED: begin
        npush = 2'd1;
        if (rvc(lo[1:0])) begin
          e0    = mk({16'h0000, lo}, fetch_addr_i, 1'b1);
          upper = 1'b1;
        end else begin
          e0 = mk(fetch_rdata_i, fetch_addr_i, 1'b0);
        end
      end
      HALF: begin
        e0    = mk({lo, hold}, hpc, 1'b0);
        npush = 2'd1;
        upper = 1'b1;
      end
      SKIP_LOW: upper = 1'b1;
      default: ;
    endcase
    // The upper half lands in whichever slot follows what the low half produced.
    if (upper) begin
      if (rvc(hi[1:0])) begin
        up_e = mk({16'h0000, hi}, a2, 1'b1);
        if (npush == 2'd0) e0 = up_e;
        else               e1 = up_e;
        npush   = npush + 2'd1;
        state_n = ALIGNED;
      end else begin
        hold_n  = hi;
        hpc_n   = a2;
        state_n = HALF;
      end
    end else begin
      state_n = ALIGNED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ALIGNED;
      hold   <= '0;
      hpc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush_i) begin
      state  <= ((RVC_EN != 0) && flush_pc_i[1]) ? SKIP_LOW : ALIGNED;
      hold   <= '0;
      hpc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) begin
        if (npush != 2'd0) mem[wr_ptr] <= e0;
        if (npush == 2'd2) mem[wr_ptr + AW'(1)] <= e1;
        state <= state_n;
        hold  <= hold_n;
        hpc   <= hpc_n;
      end
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  assign head            = mem[rd_ptr];
  assign instr_o         = head.instr;
  assign pc_o            = head.pc;
  assign is_compressed_o = head.comp;
  assign is_branch_o     = head.br;
  assign is_jal_o        = head.jal;
  assign is_jalr_o       = head.jalr;

endmodule

// File: tb/tb_riscv_pre_decoder_align.sv
// Scoreboard bench: a halfword-stream parser predicts the instruction sequence,
// a negedge monitor pops and compares whenever the DUT hands an instruction over.
module tb_riscv_pre_decoder_align;
  localparam int unsigned RVC_EN = 1;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i = '0;
  logic [31:0] fetch_addr_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        is_compressed_o;
  logic        is_branch_o;
  logic        is_jal_o;
  logic        is_jalr_o;

  always #5 clk = ~clk;

  riscv_pre_decoder_align #(.RVC_EN(RVC_EN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_rdata_i(fetch_rdata_i), .fetch_addr_i(fetch_addr_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .is_compressed_o(is_compressed_o),
    .is_branch_o(is_branch_o), .is_jal_o(is_jal_o), .is_jalr_o(is_jalr_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        br;
    logic        jal;
    logic        jalr;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] h;
  } half_t;

  exp_t  exp_q[$];
  half_t hq[$];
  logic  skip = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;
  exp_t  mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic is_c(input logic [15:0] h);
    return (RVC_EN != 0) && (h[1:0] != 2'b11);
  endfunction

  function automatic exp_t expect_of(input logic [31:0] ins, input logic [31:0] pc, input logic c);
    exp_t e;
    logic [2:0] f3;
    e = '0;
    e.instr = ins;
    e.pc = pc;
    e.c = c;
    if (c) begin
      f3 = ins[15:13];
      if (ins[1:0] == 2'd1) begin
        e.jal = (f3 == 3'd1) || (f3 == 3'd5);
        e.br  = (f3 == 3'd6) || (f3 == 3'd7);
      end
      if (ins[1:0] == 2'd2) e.jalr = (f3 == 3'd4) && (ins[11:7] != 0) && (ins[6:2] == 0);
    end else begin
      e.br   = (ins[6:0] == 7'h63);
      e.jal  = (ins[6:0] == 7'h6F);
      e.jalr = (ins[6:0] == 7'h67) && (ins[14:12] == 3'd0);
    end
    return e;
  endfunction

  task automatic model_accept(input logic [31:0] w, input logic [31:0] a);
    half_t x;
    if (!skip) begin
      x.pc = a; x.h = w[15:0]; hq.push_back(x);
    end
    skip = 1'b0;
    x.pc = a + 32'd2; x.h = w[31:16]; hq.push_back(x);
    while (hq.size() > 0) begin
      if (is_c(hq[0].h)) begin
        exp_q.push_back(expect_of({16'h0, hq[0].h}, hq[0].pc, 1'b1));
        void'(hq.pop_front());
      end else if (hq.size() >= 2) begin
        exp_q.push_back(expect_of({hq[1].h, hq[0].h}, hq[0].pc, 1'b0));
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else break;
    end
  endtask

  // Inputs change 1 ns after the rising edge; the model samples the handshake 2 ns before the next one.
  task automatic step(input logic fv, input logic [31:0] w, input logic [31:0] a,
                      input logic fl, input logic [31:0] fpc, output logic fired);
    @(posedge clk);
    #1;
    fetch_valid_i = fv; fetch_rdata_i = w; fetch_addr_i = a;
    flush_i = fl; flush_pc_i = fpc;
    instr_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
    #7;
    fired = fv && fetch_ready_o && !rst && !fl;
    if (rst) begin
      hq.delete(); exp_q.delete(); skip = 1'b0;
    end else if (fl) begin
      hq.delete(); exp_q.delete(); skip = (RVC_EN != 0) && fpc[1];
    end else if (fired) model_accept(w, a);
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, f);
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] a);
    logic f;
    f = 1'b0;
    for (int k = 0; k < 64 && !f; k++) step(1'b1, w, a, 1'b0, '0, f);
    chk("send_accepted", {31'd0, f}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; fetch_valid_i = 1'b0; flush_i = 1'b0;
    #7;
    chk("rst_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
    hq.delete(); exp_q.delete(); skip = 1'b0;
    @(posedge clk);
    #7;
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_flags", {28'd0, is_compressed_o, is_branch_o, is_jal_o, is_jalr_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #7;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !flush_i) begin
        chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, exp_q.size() != 0});
        chk("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, (int'(DEPTH) - exp_q.size()) >= 2});
        if (instr_valid_o && instr_ready_i && exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("instr", instr_o, mon_e.instr);
          chk("pc", pc_o, mon_e.pc);
          chk("flags", {28'd0, is_compressed_o, is_branch_o, is_jal_o, is_jalr_o},
              {28'd0, mon_e.c, mon_e.br, mon_e.jal, mon_e.jalr});
        end
      end
    end
  end

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0: case ($urandom_range(0, 3))
           0: h[6:0] = 7'h63;
           1: h[6:0] = 7'h6F;
           2: h[6:0] = 7'h67;
           default: h[6:0] = 7'h13;
         endcase
      1: begin h[15:13] = 3'b100; h[6:0] = 7'b0000010; end
      2: h[1:0] = 2'b01;
      default: ;
    endcase
    return h;
  endfunction

  initial begin
    logic        f;
    logic        fl;
    logic        fv;
    logic [31:0] fpc;
    logic [31:0] nxt;
    logic [31:0] w;

    do_reset();
    rdy_mode = 0;
    send(32'h00000013, 32'h0);
    send(32'h0000006F, 32'h4);
    idle(3);
    send(32'hA0014501, 32'h100);
    idle(3);
    send(32'h00134505, 32'h200);
    idle(3);
    send(32'h00000513, 32'h204);
    idle(3);
    send(32'h00134505, 32'h300);
    step(1'b0, '0, '0, 1'b1, 32'h402, f);
    send(32'h80824501, 32'h400);
    idle(3);
    send(32'h00134505, 32'hFFFFFFFC);
    send(32'h00000513, 32'h0);
    idle(3);

    rdy_mode = 1;
    send(32'hA0014501, 32'h600);
    send(32'hA0014501, 32'h604);
    idle(1);
    chk("bp_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
    rdy_mode = 0;
    idle(6);

    rdy_mode = 1;
    send(32'hA0014501, 32'h700);
    send(32'h00134505, 32'h704);
    idle(1);
    do_reset();
    rdy_mode = 0;
    send(32'h00000013, 32'h0);
    idle(3);

    rdy_mode = 2;
    nxt = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      fl  = ($urandom_range(0, 59) == 0);
      fpc = $urandom;
      fpc[0] = 1'b0;
      fv  = ($urandom_range(0, 3) != 0);
      w   = {rand_half(), rand_half()};
      step(fv, w, nxt, fl, fpc, f);
      if (fl) nxt = {fpc[31:2], 2'b00};
      else if (f) nxt = nxt + 32'd4;
    end
    rdy_mode = 0;
    idle(10);
    chk("drained_queue", exp_q.size(), 32'd0);
    chk("drained_valid", {31'd0, instr_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
